// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port word RAM between two masters.
// One access in flight at a time; every access walks IDLE -> ISSUE -> RESP.
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 30,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [31:0]           m0_wdata,
    input  logic                  m0_re,
    input  logic [3:0]            m0_we,
    output logic [31:0]           m0_rdata,
    output logic                  m0_ready,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]           m1_wdata,
    input  logic                  m1_re,
    input  logic [3:0]            m1_we,
    output logic [31:0]           m1_rdata,
    output logic                  m1_ready,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    output logic                  ram_re,
    output logic [3:0]            ram_we,
    input  logic [31:0]           ram_rdata
);

    typedef enum logic [1:0] { IDLE, ISSUE, RESP } state_t;

    state_t                state;
    logic                  grant_id;
    logic                  last_grant;
    logic                  req0;
    logic                  req1;
    logic                  pick;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [31:0]           sel_wdata;
    logic                  sel_re;
    logic [3:0]            sel_we;

    assign req0 = m0_re | (|m0_we);
    assign req1 = m1_re | (|m1_we);

    // pick = 1 selects m1; on a tie the rotating mode favours the other master
    always_comb begin
        pick = req1;
        if (req0 && req1)
            pick = (ROUND_ROBIN != 0) ? ~last_grant : 1'b0;
    end

    always_comb begin
        sel_addr  = m0_addr;
        sel_wdata = m0_wdata;
        sel_re    = m0_re;
        sel_we    = m0_we;
        if (pick) begin
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
            sel_re    = m1_re;
            sel_we    = m1_we;
        end
    end

    assign m0_rdata = ram_rdata;
    assign m1_rdata = ram_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_re     <= 1'b0;
            ram_we     <= 4'b0000;
            m0_ready   <= 1'b0;
            m1_ready   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        grant_id   <= pick;
                        last_grant <= pick;
                        ram_addr   <= sel_addr;
                        ram_wdata  <= sel_wdata;
                        ram_we     <= sel_we;
                        // a write wins over a simultaneous read request
                        ram_re     <= sel_re & ~(|sel_we);
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    ram_re   <= 1'b0;
                    ram_we   <= 4'b0000;
                    m0_ready <= ~grant_id;
                    m1_ready <= grant_id;
                    state    <= RESP;
                end
                RESP: begin
                    m0_ready <= 1'b0;
                    m1_ready <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
